// File: rtl/capp_cell_array.sv
// capp_cell_array
//   Registered content-addressable cell array. WORDS words of WIDTH bits, one
//   tag bit per word. Commands arrive on a valid/ready port; read results leave
//   on a valid/ready response port. Store and tags only change while idle, so
//   responses always reflect the array as it was when the read was accepted.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_op                0 NOP 1 SEARCH 2 SEARCH_AND 3 SEARCH_OR
//                         4 WRITE 5 READ_OR 6 READ_EACH 7 FIRST
//   cmd_key, cmd_mask     compare/write data and bit-participation mask
//   rsp_valid/rsp_ready   response handshake
//   rsp_data, rsp_index   response word and word index (READ_EACH only)
//   rsp_last, rsp_empty   final beat, response produced with no tags set
//   tags, tag_any, tag_count  tag register and its OR / population count
//
// state  | meaning
// IDLE   | accepting commands
// RESP   | single response beat held until taken
// STREAM | READ_EACH beats, one per pending tagged word
module capp_cell_array #(
  parameter int WORDS = 8,
  parameter int WIDTH = 32,
  parameter int IDXW  = $clog2(WORDS > 1 ? WORDS : 2),
  parameter int CNTW  = $clog2(WORDS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_key,
  input  logic [WIDTH-1:0] cmd_mask,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [IDXW-1:0]  rsp_index,
  output logic             rsp_last,
  output logic             rsp_empty,
  output logic [WORDS-1:0] tags,
  output logic             tag_any,
  output logic [CNTW-1:0]  tag_count
);

  typedef enum logic [2:0] {
    OP_NOP        = 3'd0,
    OP_SEARCH     = 3'd1,
    OP_SEARCH_AND = 3'd2,
    OP_SEARCH_OR  = 3'd3,
    OP_WRITE      = 3'd4,
    OP_READ_OR    = 3'd5,
    OP_READ_EACH  = 3'd6,
    OP_FIRST      = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESP   = 2'd1,
    STREAM = 2'd2
  } state_e;

  state_e           state;
  logic [WIDTH-1:0] store [WORDS];
  logic [WORDS-1:0] pending;
  logic [WORDS-1:0] match;
  logic [WORDS-1:0] pend_next;
  logic [WIDTH-1:0] or_data;
  logic             accept;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [IDXW-1:0] low_idx(input logic [WORDS-1:0] v);
    logic [IDXW-1:0] r;
    r = '0;
    for (int i = WORDS - 1; i >= 0; i--) begin
      if (v[i]) r = IDXW'(i);
    end
    return r;
  endfunction

  // True when at most one bit is set (caller guarantees at least one).
  function automatic logic one_left(input logic [WORDS-1:0] v);
    return (v & (v - WORDS'(1))) == '0;
  endfunction

  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign tag_any   = |tags;
  // Clearing the lowest pending bit yields the set still owed after this beat.
  assign pend_next = pending & (pending - WORDS'(1));

  always_comb begin
    match = '0;
    for (int w = 0; w < WORDS; w++) begin
      match[w] = ((store[w] ^ cmd_key) & cmd_mask) == '0;
    end
  end

  always_comb begin
    or_data = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (tags[w]) or_data = or_data | store[w];
    end
  end

  always_comb begin
    tag_count = '0;
    for (int w = 0; w < WORDS; w++) begin
      tag_count = tag_count + CNTW'(tags[w]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tags      <= '0;
      pending   <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_index <= '0;
      rsp_last  <= 1'b0;
      rsp_empty <= 1'b0;
      for (int w = 0; w < WORDS; w++) begin
        store[w] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            case (op_e'(cmd_op))
              OP_SEARCH:     tags <= match;
              OP_SEARCH_AND: tags <= tags & match;
              OP_SEARCH_OR:  tags <= tags | match;
              OP_WRITE: begin
                for (int w = 0; w < WORDS; w++) begin
                  if (tags[w]) store[w] <= (store[w] & ~cmd_mask) | (cmd_key & cmd_mask);
                end
              end
              // Two's-complement trick isolates the lowest set bit.
              OP_FIRST:      tags <= tags & (~tags + WORDS'(1));
              OP_READ_OR: begin
                rsp_valid <= 1'b1;
                rsp_data  <= or_data;
                rsp_index <= '0;
                rsp_last  <= 1'b1;
                rsp_empty <= ~tag_any;
                state     <= RESP;
              end
              OP_READ_EACH: begin
                rsp_valid <= 1'b1;
                if (tag_any) begin
                  pending   <= tags;
                  rsp_data  <= store[low_idx(tags)];
                  rsp_index <= low_idx(tags);
                  rsp_last  <= one_left(tags);
                  rsp_empty <= 1'b0;
                  state     <= STREAM;
                end else begin
                  rsp_data  <= '0;
                  rsp_index <= '0;
                  rsp_last  <= 1'b1;
                  rsp_empty <= 1'b1;
                  state     <= RESP;
                end
              end
              default: ;
            endcase
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        STREAM: begin
          if (rsp_ready) begin
            if (rsp_last) begin
              rsp_valid <= 1'b0;
              pending   <= '0;
              state     <= IDLE;
            end else begin
              pending   <= pend_next;
              rsp_data  <= store[low_idx(pend_next)];
              rsp_index <= low_idx(pend_next);
              rsp_last  <= one_left(pend_next);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_capp_cell_array.sv
module tb_capp_cell_array;

  localparam int WORDS = 4;
  localparam int WIDTH = 8;
  localparam int IDXW  = 2;
  localparam int CNTW  = 3;

  localparam logic [2:0] NOP = 3'd0, SRCH = 3'd1, SAND = 3'd2, SOR = 3'd3,
                         WR = 3'd4, ROR = 3'd5, REACH = 3'd6, FIRST = 3'd7;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_key;
  logic [WIDTH-1:0] cmd_mask;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic [IDXW-1:0]  rsp_index;
  logic             rsp_last;
  logic             rsp_empty;
  logic [WORDS-1:0] tags;
  logic             tag_any;
  logic [CNTW-1:0]  tag_count;

  int n_total = 0;
  int n_bad   = 0;

  capp_cell_array #(.WORDS(WORDS), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_key(cmd_key), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_index(rsp_index), .rsp_last(rsp_last), .rsp_empty(rsp_empty),
    .tags(tags), .tag_any(tag_any), .tag_count(tag_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives a command from a falling edge, returns at the falling edge after
  // the accepting rising edge.
  task automatic send(input logic [2:0] op, input logic [7:0] key, input logic [7:0] mask);
    int waited;
    waited = 0;
    while (!cmd_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) chk("send_ready_timeout", 32'(cmd_ready), 32'd1);
    cmd_op    = op;
    cmd_key   = key;
    cmd_mask  = mask;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Checks one held beat, then lets it be taken.
  task automatic take_beat(input string tag, input logic [7:0] d, input logic [1:0] idx,
                           input logic last, input logic empty);
    chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_data"},  32'(rsp_data),  32'(d));
    chk({tag, "_index"}, 32'(rsp_index), 32'(idx));
    chk({tag, "_last"},  32'(rsp_last),  32'(last));
    chk({tag, "_empty"}, 32'(rsp_empty), 32'(empty));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = NOP; cmd_key = '0; cmd_mask = '0;
    rsp_ready = 1'b0;
    #12;
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_tags", 32'(tags), 0);
    chk("rst_rsp_last", 32'(rsp_last), 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);

    // Mask 0 matches everything
    send(SRCH, 8'h00, 8'h00);
    chk("all_tags", 32'(tags), 32'hF);
    chk("all_count", 32'(tag_count), 4);
    chk("all_any", 32'(tag_any), 1);
    send(WR, 8'hA5, 8'hFF);
    send(ROR, 8'h00, 8'h00);
    take_beat("ror_a5", 8'hA5, 0, 1, 0);

    send(FIRST, 8'h00, 8'h00);
    chk("first_tags", 32'(tags), 32'h1);
    send(WR, 8'h3C, 8'hFF);
    send(SRCH, 8'h0C, 8'h0F);
    chk("srch_low", 32'(tags), 32'h1);
    send(SOR, 8'h05, 8'h0F);
    chk("sor_tags", 32'(tags), 32'hF);
    send(SAND, 8'h30, 8'hF0);
    chk("sand_tags", 32'(tags), 32'h1);
    send(NOP, 8'hFF, 8'h00);
    chk("nop_tags", 32'(tags), 32'h1);

    // Build word1=81, word2=00, word3=18 (word0 stays 3C)
    send(SRCH, 8'hA5, 8'hFF);
    chk("a5_tags", 32'(tags), 32'hE);
    send(FIRST, 8'h00, 8'h00);
    chk("first_w1", 32'(tags), 32'h2);
    send(WR, 8'h81, 8'hFF);
    send(SRCH, 8'hA5, 8'hFF);
    send(FIRST, 8'h00, 8'h00);
    chk("first_w2", 32'(tags), 32'h4);
    send(WR, 8'h00, 8'hFF);
    send(SRCH, 8'hA5, 8'hFF);
    chk("only_w3", 32'(tags), 32'h8);
    // Partial mask write: only low nibble changes, A5 -> A8, then high -> 18
    send(WR, 8'h08, 8'h0F);
    send(WR, 8'h1F, 8'hF0);
    send(SRCH, 8'h81, 8'hFF);
    send(SOR, 8'h18, 8'hFF);
    chk("tags_13", 32'(tags), 32'hA);
    chk("count_13", 32'(tag_count), 2);

    // READ_OR: latency one, cmd_ready low while held
    send(ROR, 8'h00, 8'h00);
    chk("ror_cmd_ready", 32'(cmd_ready), 0);
    take_beat("ror_99", 8'h99, 0, 1, 0);
    chk("ror_done_valid", 32'(rsp_valid), 0);
    chk("ror_done_ready", 32'(cmd_ready), 1);

    // READ_EACH with consumer always ready
    rsp_ready = 1'b1;
    send(REACH, 8'h00, 8'h00);
    chk("re0_valid", 32'(rsp_valid), 1);
    chk("re0_data", 32'(rsp_data), 32'h81);
    chk("re0_index", 32'(rsp_index), 1);
    chk("re0_last", 32'(rsp_last), 0);
    chk("re0_cmd_ready", 32'(cmd_ready), 0);
    @(negedge clk);
    chk("re1_valid", 32'(rsp_valid), 1);
    chk("re1_data", 32'(rsp_data), 32'h18);
    chk("re1_index", 32'(rsp_index), 3);
    chk("re1_last", 32'(rsp_last), 1);
    chk("re1_cmd_ready", 32'(cmd_ready), 0);
    @(negedge clk);
    chk("re_end_valid", 32'(rsp_valid), 0);
    chk("re_end_ready", 32'(cmd_ready), 1);
    rsp_ready = 1'b0;

    // READ_EACH with back-pressure; a competing command must be ignored
    send(REACH, 8'h00, 8'h00);
    cmd_op = SRCH; cmd_key = 8'h00; cmd_mask = 8'h00; cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 1);
      chk("hold_data", 32'(rsp_data), 32'h81);
      chk("hold_index", 32'(rsp_index), 1);
      chk("hold_last", 32'(rsp_last), 0);
      chk("hold_cmd_ready", 32'(cmd_ready), 0);
    end
    cmd_valid = 1'b0;
    take_beat("hold_b0", 8'h81, 1, 0, 0);
    take_beat("hold_b1", 8'h18, 3, 1, 0);
    chk("hold_tags", 32'(tags), 32'hA);
    send(ROR, 8'h00, 8'h00);
    take_beat("hold_ror", 8'h99, 0, 1, 0);

    // READ_EACH with no tags
    send(SRCH, 8'h55, 8'hFF);
    chk("none_tags", 32'(tags), 0);
    chk("none_any", 32'(tag_any), 0);
    send(REACH, 8'h00, 8'h00);
    take_beat("empty_beat", 8'h00, 0, 1, 1);
    chk("empty_done", 32'(rsp_valid), 0);
    send(ROR, 8'h00, 8'h00);
    take_beat("empty_ror", 8'h00, 0, 1, 1);

    // Reset in the middle of a stream
    send(SRCH, 8'h81, 8'hFF);
    send(SOR, 8'h18, 8'hFF);
    send(REACH, 8'h00, 8'h00);
    chk("mid_valid", 32'(rsp_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 0);
    chk("mid_rst_tags", 32'(tags), 0);
    chk("mid_rst_data", 32'(rsp_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(cmd_ready), 1);
    send(SRCH, 8'h00, 8'hFF);
    chk("post_rst_tags", 32'(tags), 32'hF);
    send(SRCH, 8'h00, 8'h00);
    chk("post_rst_m0", 32'(tags), 32'hF);
    send(ROR, 8'h00, 8'h00);
    take_beat("post_rst_ror", 8'h00, 0, 1, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/capp_cell_array.md
# capp_cell_array

Parametrised content-addressable cell array: WORDS stored words of WIDTH bits each, with one tag bit per word, driven through a valid/ready command port and a valid/ready response port. It supports the following operations:
- masked search, with replace, AND and OR combining into the tags;
- masked parallel write to all tagged words;
- OR-reduction read of tagged words;
- lowest-tag select;
- a sequenced per-word readout of all tagged words.

It is the registered, clocked successor to the combinational cell array and sits between the CAPP controller and its instruction sequencer.

## Interface
- WORDS, 8: number of stored words (≥1)
- WIDTH, 32: bits per word (≥1)
- IDXW, $clog2(WORDS>1?WORDS:2): derived, index width
- CNTW, $clog2(WORDS+1): derived, tag count width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  array can accept a command
- cmd_op  in  3  0 NOP, 1 SEARCH, 2 SEARCH_AND, 3 SEARCH_OR, 4 WRITE, 5 READ_OR, 6 READ_EACH, 7 FIRST
- cmd_key  in  WIDTH  compare/write data
- cmd_mask  in  WIDTH  1 = bit participates
- rsp_valid  out  1  response beat present
- rsp_ready  in  1  consumer accepts beat
- rsp_data  out  WIDTH  response word
- rsp_index  out  IDXW  word index (READ_EACH), 0 otherwise
- rsp_last  out  1  final beat of response
- rsp_empty  out  1  response produced with no tags set
- tags  out  WORDS  registered tag vector
- tag_any  out  1  |tags
- tag_count  out  CNTW  population count of tags

## Operation
- A command is accepted on a rising edge where cmd_valid && cmd_ready.
- match[w] = ((store[w] ^ cmd_key) & cmd_mask) == 0. A mask of 0 matches every word.

Per-opcode behaviour:
- SEARCH: tags ← match.
- SEARCH_AND: tags ← tags & match.
- SEARCH_OR: tags ← tags | match.
- WRITE: for each w with tags[w], store[w] ← (store[w] & ~mask) | (key & mask). Tags are unchanged.
- FIRST: tags ← lowest set bit of tags only. All-zero tags stay zero.
- NOP: no effect.
- READ_OR: one beat. rsp_data = OR of store[w] over tagged w, rsp_index=0, rsp_last=1, rsp_empty=~tag_any.
- READ_EACH: snapshots tags into a pending vector. Emits one beat per tagged word, in ascending index order: rsp_data=store[w], rsp_index=w, rsp_last=1 when only one pending bit remains. With zero tags it emits a single beat: data 0, index 0, last=1, empty=1. Tags are not modified.

FSM states:
- IDLE: cmd_ready=1.
- RESP: single beat held.
- STREAM: READ_EACH beats.

FSM transitions:
- IDLE→RESP on accept of READ_OR, or READ_EACH with zero tags.
- IDLE→STREAM on accept of READ_EACH with nonzero tags.
- RESP→IDLE on rsp_valid && rsp_ready.
- STREAM: each handshake clears the lowest pending bit. The handshake on the rsp_last beat returns the FSM to IDLE.
- cmd_ready=0 outside IDLE, so store and tags are frozen during responses.

Response port rules:
- rsp_* hold stable while rsp_valid && !rsp_ready.

Reset values (asynchronous on rst_n low; state forced to IDLE, including mid-stream):
- store all 0
- tags 0
- pending 0
- rsp_valid 0
- rsp_data 0
- rsp_index 0
- rsp_last 0
- rsp_empty 0
- cmd_ready 1 once rst_n is high

## Timing
- Search, write, FIRST and NOP: accepted at edge N; updated tags and store are visible after edge N. tag_any and tag_count are combinational from the tags register.
- READ_OR and READ_EACH: rsp_valid rises the cycle after acceptance (latency 1). The data reflects store as of acceptance.
- STREAM with rsp_ready held high: one beat per cycle, back-to-back. K tagged words take K cycles. cmd_ready returns high in the cycle after the last handshake.
- cmd_valid during RESP or STREAM is ignored, not queued. The upstream holds it until cmd_ready.
- Simultaneous handshake and reset: reset wins.

## Test plan
Bench configuration: WORDS=4, WIDTH=8.

- Reset, then SEARCH with mask 0x00 → tags=4'b1111, tag_count=4. Then WRITE key 0xA5 mask 0xFF → all words 0xA5.
- FIRST → tags=0001. WRITE key 0x3C mask 0xFF → word0=0x3C. SEARCH key 0x0C mask 0x0F → tags=0001. SEARCH_OR key 0x05 mask 0x0F → tags=1111. SEARCH_AND key 0x30 mask 0xF0 → tags=0001.
- Tag words 1 and 3, with word1=0x81 and word3=0x18. READ_OR → one beat: data=0x99, last=1, empty=0, one cycle after accept.
- Same tags, READ_EACH with rsp_ready high → beats (0x81, idx1, last0), (0x18, idx3, last1) on consecutive cycles. cmd_ready is 0 throughout and 1 the next cycle.
- READ_EACH with rsp_ready low for 3 cycles → the first beat is held stable. Commands offered meanwhile are not accepted and store/tags are unchanged. With tags=0 → single beat data 0, empty=1, last=1.
- Assert rst_n low mid-STREAM → rsp_valid drops immediately, tags=0, store=0. After release, cmd_ready=1 and a search with mask 0 gives tags=1111 with data 0.
